// File: rtl/shift_register_n.sv
// Parametrised universal register: hold, load, shift, rotate and count, plus a
// burst engine that runs N shift/rotate steps with a busy/done handshake.
module shift_register_n #(
    parameter int              WIDTH     = 8,
    parameter int              CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       burst_mode;
    logic             is_burst_op;

    // Only shift/rotate encodings (010..101) may start a burst.
    assign is_burst_op = (mode >= 3'b010) && (mode <= 3'b101);

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

    function automatic logic [WIDTH-1:0] next_q(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        case (op)
            3'b000:  next_q = cur;
            3'b001:  next_q = din;
            3'b010:  next_q = {cur[WIDTH-2:0], sr};
            3'b011:  next_q = {sl, cur[WIDTH-1:1]};
            3'b100:  next_q = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  next_q = {cur[0], cur[WIDTH-1:1]};
            3'b110:  next_q = cur + WIDTH'(1);
            default: next_q = cur - WIDTH'(1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            q          <= RESET_VAL;
            busy       <= 1'b0;
            done       <= 1'b0;
            state      <= IDLE;
            remaining  <= '0;
            burst_mode <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (start && is_burst_op) begin
                            state      <= BUSY;
                            busy       <= 1'b1;
                            remaining  <= nshift;
                            burst_mode <= mode;
                        end else begin
                            q <= next_q(mode, q, d, sin_l, sin_r);
                        end
                    end
                end
                BUSY: begin
                    if (en) begin
                        if (remaining != '0) begin
                            q         <= next_q(burst_mode, q, d, sin_l, sin_r);
                            remaining <= remaining - CNT_W'(1);
                        end
                        // Final step (or an empty burst) retires this cycle.
                        if (remaining <= CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_n.sv
// Bench for shift_register_n (WIDTH=8): per-scenario tasks feeding an expected
// queue of {busy, done, q} that is popped after every rising edge.
module tb_shift_register_n;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rest;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic         start;
    logic [C-1:0] nshift;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic         busy;
    logic         done;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    int           n_tests = 0;
    int           n_fail  = 0;

    shift_register_n #(.WIDTH(W), .CNT_W(C), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rest(rest), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .nshift(nshift),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic drive(input logic e_i, input logic [2:0] m, input logic s,
                         input logic [C-1:0] n, input logic [W-1:0] dv,
                         input logic sl, input logic sr);
        en = e_i; mode = m; start = s; nshift = n; d = dv; sin_l = sl; sin_r = sr;
    endtask

    task automatic test_reset;
        rest = 1'b0;
        drive(1'b0, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
        #2;
        n_tests++;
        if ({busy, done, q} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b done=%b q=%h, want 0 0 00", busy, done, q);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, q} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_held: got busy=%b done=%b q=%h, want 0 0 00", busy, done, q);
        end
        rest = 1'b1;
        drive(1'b1, 3'b001, 1'b0, '0, 8'hA5, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'hA5});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({busy, done, q} !== e || sout_l !== 1'b1 || sout_r !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_load: got busy=%b done=%b q=%h sl=%b sr=%b, want %b %b %h 1 1",
                     busy, done, q, sout_l, sout_r, e[W+1], e[W], e[W-1:0]);
        end
    endtask

    task automatic test_shift_hold;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, 3'b010, 1'b0, '0, 8'h00, 1'b0, 1'b1);
            else drive(1'b0, 3'($urandom_range(7)), 1'($urandom_range(1)), 4'd3,
                       8'($urandom), 1'b1, 1'b1);
            exp_q.push_back({2'b00, 8'h4B});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL shift_hold[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_burst_rotate;
        logic [W+1:0] tbl[6];
        tbl = '{{2'b00, 8'hA5}, {2'b10, 8'hA5}, {2'b10, 8'hD2},
                {2'b10, 8'h69}, {2'b01, 8'hB4}, {2'b00, 8'hB4}};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b1, 3'b001, 1'b0, '0, 8'hA5, 1'b0, 1'b0);
                1: drive(1'b1, 3'b101, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
                // Burst must ignore start/mode/d/nshift while busy.
                2, 3, 4: drive(1'b1, 3'b001, 1'b1, 4'd9, 8'h00, 1'b1, 1'b1);
                default: drive(1'b1, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            endcase
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL burst_rotate[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_burst_stall;
        logic [W+1:0] tbl[9];
        tbl = '{{2'b10, 8'hB4}, {2'b10, 8'hB4}, {2'b10, 8'hB4}, {2'b10, 8'h68},
                {2'b01, 8'hD0}, {2'b00, 8'hD0},
                {2'b10, 8'hD0}, {2'b01, 8'hD0}, {2'b00, 8'hD0}};
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: drive(1'b1, 3'b010, 1'b1, 4'd2, 8'h00, 1'b1, 1'b0);
                1, 2: drive(1'b0, 3'b010, 1'b0, '0, 8'h00, 1'b1, 1'b0);
                3, 4: drive(1'b1, 3'b110, 1'b0, '0, 8'h00, 1'b1, 1'b0);
                6: drive(1'b1, 3'b011, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1);
                default: drive(1'b1, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            endcase
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL burst_stall[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] tbl[5];
        tbl = '{{2'b10, 8'hD0}, {2'b01, 8'hA1}, {2'b10, 8'hA1},
                {2'b01, 8'h43}, {2'b00, 8'h43}};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 2: drive(1'b1, 3'b100, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
                default: drive(1'b1, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            endcase
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_counter;
        logic [W-1:0] tbl[8];
        tbl = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD};
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive(1'b1, 3'b001, 1'b0, '0, 8'hFE, 1'b0, 1'b0);
            // A start with a counting mode is ignored; the count still applies.
            else if (i == 1) drive(1'b1, 3'b110, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
            else if (i < 4) drive(1'b1, 3'b110, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            else drive(1'b1, 3'b111, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            exp_q.push_back({2'b00, tbl[i]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL counter[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [W+1:0] tbl[3];
        tbl = '{{2'b10, 8'hFD}, {2'b10, 8'hFB}, {2'b10, 8'hF7}};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 3'b100, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
            else drive(1'b1, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL mid_burst_pre[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
        #2 rest = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, q} !== 10'h000) begin
            n_fail++;
            $display("FAIL mid_burst_reset: got busy=%b done=%b q=%h, want 0 0 00", busy, done, q);
        end
        @(posedge clk); #1;
        rest = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                drive(1'b1, 3'b000, 1'b0, '0, 8'h00, 1'b0, 1'b0);
                exp_q.push_back({2'b00, 8'h00});
            end else begin
                drive(1'b1, 3'b001, 1'b0, '0, 8'h3C, 1'b0, 1'b0);
                exp_q.push_back({2'b00, 8'h3C});
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e) begin
                n_fail++;
                $display("FAIL mid_burst_after[%0d]: got busy=%b done=%b q=%h, want %b %b %h",
                         i, busy, done, q, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_random_direct;
        logic [W-1:0] m_q;
        logic [W-1:0] nxt;
        m_q = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(3) != 0), 3'($urandom_range(7)), 1'b0, '0,
                  8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
            nxt = m_q;
            if (en) begin
                case (mode)
                    3'd1: nxt = d;
                    3'd2: nxt = (m_q << 1) | {7'd0, sin_r};
                    3'd3: nxt = (m_q >> 1) | {sin_l, 7'd0};
                    3'd4: nxt = (m_q << 1) | (m_q >> 7);
                    3'd5: nxt = (m_q >> 1) | (m_q << 7);
                    3'd6: nxt = 8'((int'(m_q) + 1) % 256);
                    3'd7: nxt = 8'((int'(m_q) + 255) % 256);
                    default: nxt = m_q;
                endcase
            end
            m_q = nxt;
            exp_q.push_back({2'b00, nxt});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, done, q} !== e || sout_l !== e[W-1] || sout_r !== e[0]) begin
                n_fail++;
                $display("FAIL random_direct[%0d]: got busy=%b done=%b q=%h sl=%b sr=%b, want %b %b %h",
                         i, busy, done, q, sout_l, sout_r, e[W+1], e[W], e[W-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_hold();
        test_burst_rotate();
        test_burst_stall();
        test_back_to_back();
        test_counter();
        test_reset_mid_burst();
        test_random_direct();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
